sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//   Synchronous single-clock FIFO: the design under test whose fifo_if pins feed the verification monitor.
//   Buffers FIFO_WIDTH-bit words with per-cycle handshake feedback (wr_ack, overflow, underflow)
//   and occupancy flags (full, almostfull, empty, almostempty) for the producer and consumer.
// PARAMETERS
//   FIFO_WIDTH  16  data word width in bits
//   FIFO_DEPTH  8   number of entries; legal range >= 4; need not be a power of 2
// PORTS
//   clk          in   1           single clock; all state updates on its rising edge
//   rst_n        in   1           reset, asynchronous, active-low
//   data_in      in   FIFO_WIDTH  write data
//   wr_en        in   1           write request
//   rd_en        in   1           read request
//   data_out     out  FIFO_WIDTH  read data, registered
//   wr_ack       out  1           registered: the previous cycle's write was accepted
//   overflow     out  1           registered: the previous cycle's write was rejected (FIFO full)
//   underflow    out  1           registered: the previous cycle's read was rejected (FIFO empty)
//   full         out  1           combinational: count == FIFO_DEPTH
//   almostfull   out  1           combinational: count == FIFO_DEPTH-1
//   empty        out  1           combinational: count == 0
//   almostempty  out  1           combinational: count == 1
//   count        out  CNT_W       occupancy; present only with SYNC_FIFO_COUNT_EN
// BEHAVIOUR
//   - State: mem[FIFO_DEPTH], wr_ptr/rd_ptr (PTR_W = $clog2(FIFO_DEPTH)), count (CNT_W = $clog2(FIFO_DEPTH+1)).
//   - Reset (rst_n=0, any time, asynchronous): wr_ptr = rd_ptr = count = 0;
//     data_out, wr_ack, overflow and underflow all = 0.
//     Flags follow count: empty=1, the other three = 0. mem is not reset. Any in-flight operation is discarded.
//   - Write: wr_en & !full -> mem[wr_ptr] <= data_in, wr_ptr advances, wr_ack=1 next cycle.
//     wr_en & full -> no store, overflow=1 and wr_ack=0 next cycle. !wr_en -> wr_ack=0 and overflow=0 next cycle.
//   - Read: rd_en & !empty -> data_out <= mem[rd_ptr] (1-cycle latency), rd_ptr advances.
//     rd_en & empty -> data_out holds its value, underflow=1 next cycle. !rd_en -> underflow=0, data_out holds.
//   - full and empty are sampled at the start of the cycle, before that cycle's updates:
//     - both requests, !full & !empty: both proceed; count unchanged.
//     - both requests while full: read proceeds; write is rejected (overflow=1); count -> FIFO_DEPTH-1.
//     - both requests while empty: write proceeds (wr_ack=1); read is rejected (underflow=1); count -> 1.
//   - Pointer wrap: when a pointer equals FIFO_DEPTH-1 and advances, it goes to 0.
//     Wrap is explicit, not modulo 2^PTR_W, so non-power-of-2 depths work.
//   - count changes by +1 for an accepted write only, -1 for an accepted read only, 0 otherwise.
//     count never exceeds FIFO_DEPTH and never goes below 0.
// CONFIGURATION
//   SYNC_FIFO_COUNT_EN defined:
//     - count is an output port (CNT_W bits) equal to the internal occupancy register.
//     - Its reset value is 0; it updates on the same edge as the pointers.
//   SYNC_FIFO_COUNT_EN undefined:
//     - The count port does not exist; occupancy stays internal.
//     - All other behaviour is identical.
// STRUCTURE
//   - shared_pkg: FIFO_WIDTH_DEF=16 and FIFO_DEPTH_DEF=8 constants, used as parameter defaults
//     by the DUT, the interface and the bench.
//   - One sub-module, fifo_ctrl: owns wr_ptr, rd_ptr and count; computes the accept/reject
//     decisions and all four flags.
//   - sync_fifo holds mem, the data_out register, the handshake registers and the fifo_ctrl instance.
// TESTING (FIFO_WIDTH=16, FIFO_DEPTH=8)
//   1 reset mid-fill: 3 writes, then rst_n=0 -> immediately empty=1, wr_ack=overflow=underflow=0, data_out=0;
//     a read after release -> underflow=1.
//   2 fill: writes 0x0001..0x0008 -> wr_ack=1 on each; almostfull=1 after the 7th; full=1 after the 8th;
//     9th write 0x0009 -> overflow=1, wr_ack=0, contents unchanged.
//   3 drain: 8 reads -> data_out = 0x0001..0x0008 in order, 1 cycle after each rd_en; almostempty=1 at count 1;
//     9th read -> underflow=1, data_out holds 0x0008.
//   4 empty + simultaneous wr_en=rd_en=1, data_in=0xABCD -> wr_ack=1, underflow=1, count=1;
//     next read -> data_out=0xABCD.
//   5 full (0x0010..0x0017) + simultaneous wr/rd, data_in=0xFFFF -> data_out=0x0010, overflow=1,
//     count=7; 0xFFFF is never read out.
//   6 wrap: hold count at 3 with 20 cycles of simultaneous wr/rd, data 0x0100..0x0113 ->
//     output sequence exact, no flag glitches, both pointers wrap at least twice.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared FIFO sizing defaults used by the DUT and its bench.
// Optional occupancy port is enabled with SYNC_FIFO_COUNT_EN.
package shared_pkg;
    localparam int unsigned FIFO_WIDTH_DEF = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy control for sync_fifo: accept/reject decisions and occupancy flags.
// Exposes the occupancy register as 'count' only when SYNC_FIFO_COUNT_EN is defined.
module fifo_ctrl
    import shared_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic             wr_accept,
    output logic             rd_accept,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             full,
    output logic             almostfull,
    output logic             empty,
    output logic             almostempty
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(FIFO_DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full        = (count_q == DEPTH_C);
    assign almostfull  = (count_q == DEPTH_M1_C);
    assign empty       = (count_q == '0);
    assign almostempty = (count_q == CNT_W'(1));

    // Flags are the pre-update state, so a simultaneous request on full/empty
    // lets the opposite side through while rejecting this one.
    assign wr_accept = wr_en & ~full;
    assign rd_accept = rd_en & ~empty;

    // Explicit wrap keeps non-power-of-2 depths correct.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST_C) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST_C) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
`ifdef SYNC_FIFO_COUNT_EN
    assign count = count_q;
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and per-cycle handshake feedback.
// Define SYNC_FIFO_COUNT_EN to expose the occupancy register on the 'count' port.
module sync_fifo
    import shared_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
`ifdef SYNC_FIFO_COUNT_EN
    ,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    fifo_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_accept   (wr_accept),
        .rd_accept   (rd_accept),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .count       (count)
`endif
    );

    // Storage is deliberately not reset; only accepted entries are ever read.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_accept;
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: vector table plus hand-written reset and wrap sequences.
module tb_sync_fifo;
    import shared_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_out;
    logic        wr_ack, overflow, underflow;
    logic        full, almostfull, empty, almostempty;
`ifdef SYNC_FIFO_COUNT_EN
    logic [3:0]  count;
`endif

    sync_fifo #(
        .FIFO_WIDTH (FIFO_WIDTH_DEF),
        .FIFO_DEPTH (FIFO_DEPTH_DEF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty)
`ifdef SYNC_FIFO_COUNT_EN
        ,
        .count       (count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic        ack;
        logic        ovf;
        logic        und;
        logic [15:0] dout;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic w, input logic r, input logic [15:0] d,
                                input logic ack, input logic ovf, input logic und,
                                input logic [15:0] dout, input logic [3:0] cnt);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.ack = ack; v.ovf = ovf; v.und = und;
        v.dout = dout; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compares every output against expectations; flags follow the expected occupancy.
    task automatic check_all(input string tag, input logic ack, input logic ovf,
                             input logic und, input logic [15:0] dout, input logic [3:0] cnt);
        check({tag, ".wr_ack"}, 32'(wr_ack), 32'(ack));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(und));
        check({tag, ".data_out"}, 32'(data_out), 32'(dout));
        check({tag, ".full"}, 32'(full), 32'(cnt == 4'd8));
        check({tag, ".almostfull"}, 32'(almostfull), 32'(cnt == 4'd7));
        check({tag, ".empty"}, 32'(empty), 32'(cnt == 4'd0));
        check({tag, ".almostempty"}, 32'(almostempty), 32'(cnt == 4'd1));
`ifdef SYNC_FIFO_COUNT_EN
        check({tag, ".count"}, 32'(count), 32'(cnt));
`endif
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d);
        wr_en = w;
        rd_en = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fill / overflow
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 16'(i), 1'b1, 1'b0, 1'b0, 16'h0, 4'(i));
        add(1'b1, 1'b0, 16'h0009, 1'b0, 1'b1, 1'b0, 16'h0, 4'd8);
        // Drain / underflow
        for (int k = 1; k <= 8; k++) add(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'(k), 4'(8 - k));
        add(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0008, 4'd0);
        // Simultaneous request while empty
        add(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'h0008, 4'd1);
        add(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'hABCD, 4'd0);
        // Simultaneous request while full
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 16'(16'h10 + i), 1'b1, 1'b0, 1'b0, 16'hABCD, 4'(i + 1));
        add(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0010, 4'd7);
        for (int k = 1; k <= 7; k++) add(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 16'(16'h10 + k), 4'(7 - k));
        add(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0017, 4'd0);

        // Reset mid-fill, asserted between clock edges
        repeat (2) @(posedge clk);
        #1;
        check_all("por", 1'b0, 1'b0, 1'b0, 16'h0, 4'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h0011);
        step(1'b1, 1'b0, 16'h0022);
        step(1'b1, 1'b0, 16'h0033);
        check_all("prefill", 1'b1, 1'b0, 1'b0, 16'h0, 4'd3);
        wr_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 1'b0, 16'h0, 4'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 16'h0);
        check_all("rd_after_rst", 1'b0, 1'b0, 1'b1, 16'h0, 4'd0);

        foreach (tbl[n]) begin
            step(tbl[n].wr, tbl[n].rd, tbl[n].din);
            check_all($sformatf("vec[%0d]", n), tbl[n].ack, tbl[n].ovf, tbl[n].und,
                      tbl[n].dout, tbl[n].cnt);
        end

        // Wrap: occupancy held at 3 while 20 simultaneous transfers walk both pointers round twice
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h00A0 + i));
        check_all("wrap_pre", 1'b1, 1'b0, 1'b0, 16'h0017, 4'd3);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 16'(16'h0100 + i));
            check_all($sformatf("wrap[%0d]", i), 1'b1, 1'b0, 1'b0,
                      (i < 3) ? 16'(16'h00A0 + i) : 16'(16'h0100 + i - 3), 4'd3);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h0);
            check_all($sformatf("wrap_drain[%0d]", i), 1'b0, 1'b0, 1'b0,
                      16'(16'h0111 + i), 4'(2 - i));
        end
        step(1'b0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
